// File: rtl/video_timing_pkg.sv
// video_timing_pkg: horizontal state enum, 1080p60 defaults and region boundary helper.
package video_timing_pkg;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} h_state_t;
  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FRONT_1080P  = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BACK_1080P   = 148;
  localparam int V_TOTAL_1080P  = 1125;
  localparam int V_ACTIVE_1080P = 1080;
  function automatic int region_start(input h_state_t s, input int ha, input int hf, input int hs);
    return s == ACTIVE ? 0 : s == FRONT ? ha : s == SYNC ? ha + hf : ha + hf + hs;
  endfunction
endpackage

// File: rtl/line_counter.sv
// line_counter: vertical line counter with wrap and active-line qualifier.
module line_counter
  import video_timing_pkg::*;
#(
  parameter int busWidth = 12,
  parameter int vTotal   = V_TOTAL_1080P,
  parameter int vActive  = V_ACTIVE_1080P
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_advance,
  output logic [busWidth-1:0] o_line,
  output logic                o_line_active
);
  localparam logic [busWidth-1:0] LAST = busWidth'(vTotal - 1);
  localparam logic [busWidth-1:0] ACT  = busWidth'(vActive);
  logic [busWidth-1:0] r_line;
  always_ff @(posedge clock) begin
    if (reset) r_line <= '0;
    else if (i_advance) r_line <= (r_line == LAST) ? '0 : r_line + busWidth'(1);
  end
  assign o_line = r_line;
  assign o_line_active = r_line < ACT;
endmodule

// File: rtl/line_timing_gen.sv
// line_timing_gen: horizontal raster FSM with porch/sync decode, external clear and line counter.
module line_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   busWidth = 12,
  parameter int   hActive  = H_ACTIVE_1080P,
  parameter int   hFront   = H_FRONT_1080P,
  parameter int   hSyncLen = H_SYNC_1080P,
  parameter int   hBack    = H_BACK_1080P,
  parameter int   vTotal   = V_TOTAL_1080P,
  parameter int   vActive  = V_ACTIVE_1080P,
  parameter logic hSyncPol = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                hCountReset_n,
  output logic [busWidth-1:0] counterVal,
  output logic [busWidth-1:0] lineCount,
  output logic                activeVideo,
  output logic                hSyncOut,
  output logic                lineEnd,
  output logic                frameStart
);
  localparam int hTotal = hActive + hFront + hSyncLen + hBack;
  localparam logic [busWidth-1:0] FRONT_AT = busWidth'(region_start(FRONT, hActive, hFront, hSyncLen));
  localparam logic [busWidth-1:0] SYNC_AT  = busWidth'(region_start(SYNC, hActive, hFront, hSyncLen));
  localparam logic [busWidth-1:0] BACK_AT  = busWidth'(region_start(BACK, hActive, hFront, hSyncLen));
  localparam logic [busWidth-1:0] LAST     = busWidth'(hTotal - 1);
  h_state_t            r_state, w_state_nxt;
  logic [busWidth-1:0] r_count, w_count_nxt;
  logic                w_wrap, w_advance, w_line_active;
  // State is derived from the next count, so empty regions fall through in one step.
  always_comb begin
    w_wrap      = r_count == LAST;
    w_advance   = enable && (w_wrap || !hCountReset_n);
    w_count_nxt = (!hCountReset_n || w_wrap) ? '0 : r_count + busWidth'(1);
    w_state_nxt = w_count_nxt < FRONT_AT ? ACTIVE :
                  w_count_nxt < SYNC_AT  ? FRONT  :
                  w_count_nxt < BACK_AT  ? SYNC   : BACK;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_state <= ACTIVE;
    end else if (enable) begin
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end
  line_counter #(.busWidth(busWidth), .vTotal(vTotal), .vActive(vActive)) u_line (
    .clock         (clock),
    .reset         (reset),
    .i_advance     (w_advance),
    .o_line        (lineCount),
    .o_line_active (w_line_active)
  );
  assign counterVal  = r_count;
  assign activeVideo = !reset && r_state == ACTIVE && w_line_active;
  assign hSyncOut    = (!reset && r_state == SYNC) ? hSyncPol : ~hSyncPol;
  assign lineEnd     = !reset && w_advance;
  assign frameStart  = !reset && enable && r_count == '0 && lineCount == '0;
endmodule

// File: tb/tb_line_timing_gen.sv
// tb_line_timing_gen: directed checks on a 1080p instance and a tiny-raster instance (hFront=0, low sync).
module tb_line_timing_gen;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic d_reset, d_en, d_clr_n, d_act, d_hs, d_le, d_fs;
  logic [11:0] d_cnt, d_line;
  logic s_reset, s_en, s_clr_n, s_act, s_hs, s_le, s_fs;
  logic [11:0] s_cnt, s_line;

  line_timing_gen d (
    .clock(clock), .reset(d_reset), .enable(d_en), .hCountReset_n(d_clr_n),
    .counterVal(d_cnt), .lineCount(d_line), .activeVideo(d_act),
    .hSyncOut(d_hs), .lineEnd(d_le), .frameStart(d_fs)
  );

  line_timing_gen #(
    .hActive(8), .hFront(0), .hSyncLen(4), .hBack(4),
    .vTotal(5), .vActive(3), .hSyncPol(1'b0)
  ) s (
    .clock(clock), .reset(s_reset), .enable(s_en), .hCountReset_n(s_clr_n),
    .counterVal(s_cnt), .lineCount(s_line), .activeVideo(s_act),
    .hSyncOut(s_hs), .lineEnd(s_le), .frameStart(s_fs)
  );

  typedef struct {int cnt; int act; int hs; int le;} vec_t;
  vec_t vecs[8];
  int checks = 0, failures = 0, m = 0, ln = 0;
  int le_pulses, fs_pulses, n_en;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_d();
    tick();
    if (d_en) begin
      if (m == 2199) begin
        m = 0;
        ln = (ln + 1) % 1125;
      end else m++;
    end
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < 2300 && m != c; k++) step_d();
  endtask

  initial begin
    vecs[0] = '{0, 1, 0, 0};
    vecs[1] = '{1919, 1, 0, 0};
    vecs[2] = '{1920, 0, 0, 0};
    vecs[3] = '{2007, 0, 0, 0};
    vecs[4] = '{2008, 0, 1, 0};
    vecs[5] = '{2051, 0, 1, 0};
    vecs[6] = '{2052, 0, 0, 0};
    vecs[7] = '{2199, 0, 0, 1};
    d_reset = 1; d_en = 1; d_clr_n = 1;
    s_reset = 1; s_en = 0; s_clr_n = 1;
    tick();
    tick();
    chk("rst_cnt", int'(d_cnt), 0);
    chk("rst_line", int'(d_line), 0);
    chk("rst_act", int'(d_act), 0);
    chk("rst_hs", int'(d_hs), 0);
    chk("rst_le", int'(d_le), 0);
    chk("rst_fs", int'(d_fs), 0);
    d_reset = 0;
    #1;
    chk("post_rst_act", int'(d_act), 1);
    chk("post_rst_fs", int'(d_fs), 1);
    m = 0; ln = 0; le_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2300 && m != vecs[i].cnt; k++) begin
        step_d();
        le_pulses += int'(d_le);
      end
      chk($sformatf("sweep_cnt@%0d", vecs[i].cnt), int'(d_cnt), vecs[i].cnt);
      chk($sformatf("sweep_act@%0d", vecs[i].cnt), int'(d_act), vecs[i].act);
      chk($sformatf("sweep_hs@%0d", vecs[i].cnt), int'(d_hs), vecs[i].hs);
      chk($sformatf("sweep_le@%0d", vecs[i].cnt), int'(d_le), vecs[i].le);
    end
    step_d();
    chk("wrap_cnt", int'(d_cnt), 0);
    chk("wrap_line", int'(d_line), 1);
    chk("wrap_le", int'(d_le), 0);
    chk("wrap_fs", int'(d_fs), 0);
    chk("le_pulses", le_pulses, 1);

    run_to(1921);
    d_clr_n = 0;
    #1;
    chk("clr_le", int'(d_le), 1);
    tick();
    d_clr_n = 1;
    m = 0; ln = 2;
    #1;
    chk("clr_cnt", int'(d_cnt), 0);
    chk("clr_line", int'(d_line), 2);
    chk("clr_act", int'(d_act), 1);
    chk("clr_hs", int'(d_hs), 0);

    run_to(2199);
    d_clr_n = 0;
    tick();
    d_clr_n = 1;
    m = 0; ln = 3;
    #1;
    chk("clrwrap_cnt", int'(d_cnt), 0);
    chk("clrwrap_line", int'(d_line), 3);

    run_to(2100);
    n_en = 0;
    for (int k = 0; k < 300; k++) begin
      d_en = 1'($urandom_range(0, 1));
      #1;
      if (!d_en) begin
        chk("dis_le", int'(d_le), 0);
        chk("dis_fs", int'(d_fs), 0);
      end else n_en++;
      step_d();
    end
    d_en = 1;
    #1;
    chk("rand_cnt", int'(d_cnt), (2100 + n_en) % 2200);
    chk("rand_line", int'(d_line), (2100 + n_en >= 2200) ? 4 : 3);

    run_to(2030);
    chk("sync_hs", int'(d_hs), 1);
    d_reset = 1;
    #1;
    chk("rst_sync_hs", int'(d_hs), 0);
    chk("rst_sync_act", int'(d_act), 0);
    tick();
    chk("rst_sync_cnt", int'(d_cnt), 0);
    chk("rst_sync_line", int'(d_line), 0);
    chk("rst_sync_le", int'(d_le), 0);
    d_reset = 0;
    #1;
    chk("rel_act", int'(d_act), 1);
    chk("rel_fs", int'(d_fs), 1);
    chk("rel_hs", int'(d_hs), 0);
    m = 0; ln = 0;
    step_d();
    chk("rel1_cnt", int'(d_cnt), 1);
    chk("rel1_hs", int'(d_hs), 0);

    s_en = 1;
    tick();
    tick();
    s_reset = 0;
    #1;
    fs_pulses = 0;
    for (int k = 0; k < 160; k++) begin
      int c, l;
      c = k % 16;
      l = (k / 16) % 5;
      chk($sformatf("s_cnt@%0d", k), int'(s_cnt), c);
      chk($sformatf("s_line@%0d", k), int'(s_line), l);
      chk($sformatf("s_act@%0d", k), int'(s_act), (c < 8 && l < 3) ? 1 : 0);
      chk($sformatf("s_hs@%0d", k), int'(s_hs), (c >= 8 && c < 12) ? 0 : 1);
      chk($sformatf("s_le@%0d", k), int'(s_le), (c == 15) ? 1 : 0);
      chk($sformatf("s_fs@%0d", k), int'(s_fs), (c == 0 && l == 0) ? 1 : 0);
      fs_pulses += int'(s_fs);
      tick();
    end
    chk("s_fs_pulses", fs_pulses, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
